// File: rtl/ollar_pkg.sv
// ollar_pkg: shared constants, port id and pipeline stage record for the OLLAR memory arbiter.
package ollar_pkg;
  localparam int NUM_PORTS = 4;
  localparam int BUS_AW = 32;
  localparam int WORD_W = 32;
  typedef logic [1:0] port_t;
  typedef struct packed {
    logic valid;
    port_t port;
    logic [BUS_AW-1:0] addr;
    logic [WORD_W-1:0] wdata;
    logic we;
  } stage_t;
  function automatic logic [NUM_PORTS-1:0] onehot(input port_t p);
    return NUM_PORTS'(1) << p;
  endfunction
endpackage

// File: rtl/ollar_ram.sv
// ollar_ram: single-port synchronous word RAM with registered read data.
module ollar_ram #(
  parameter int ADDR_WIDTH = 10,
  parameter int DATA_WIDTH = 32
) (
  input logic clk,
  input logic we,
  input logic [ADDR_WIDTH-1:0] addr,
  input logic [DATA_WIDTH-1:0] wdata,
  output logic [DATA_WIDTH-1:0] rdata
);
  logic [DATA_WIDTH-1:0] mem [2**ADDR_WIDTH];
  always_ff @(posedge clk) begin
    if (we) mem[addr] <= wdata;
    rdata <= mem[addr];
  end
endmodule

// File: rtl/ollar_mem_arbiter.sv
// ollar_mem_arbiter: four-port round-robin arbiter in front of a shared single-port RAM, 2-cycle latency.
// Optional OLLAR_ARB_RANGE_CHECK_EN adds Err and rejects addresses beyond the RAM depth.
module ollar_mem_arbiter
  import ollar_pkg::*;
#(
  parameter int ADDR_WIDTH = 10,
  parameter int DATA_WIDTH = WORD_W
) (
  input logic CLOCK_PIN,
  input logic RESET_PIN,
  input logic [NUM_PORTS-1:0] Req,
  input logic [NUM_PORTS-1:0] Write,
  input logic [NUM_PORTS*BUS_AW-1:0] Address,
  input logic [NUM_PORTS*DATA_WIDTH-1:0] WData,
  output logic [NUM_PORTS*DATA_WIDTH-1:0] RData,
  output logic [NUM_PORTS-1:0] Ack
`ifdef OLLAR_ARB_RANGE_CHECK_EN
  ,
  output logic [NUM_PORTS-1:0] Err
`endif
);
  stage_t a, b;
  port_t last, gnt;
  logic [NUM_PORTS-1:0] pend, elig, rot;
  logic [2*NUM_PORTS-1:0] dbl;
  logic [DATA_WIDTH-1:0] rdata;
  logic a_bad, b_bad, ram_we, unused;
  // Rotate eligibility so bit 0 is the port right after last; first set bit wins.
  always_comb begin
    pend = (a.valid ? onehot(a.port) : '0) | (b.valid ? onehot(b.port) : '0);
    elig = Req & ~pend;
    dbl = {elig, elig} >> ({1'b0, last} + 3'd1);
    rot = dbl[NUM_PORTS-1:0];
    gnt = last + 2'd1 + (rot[0] ? 2'd0 : rot[1] ? 2'd1 : rot[2] ? 2'd2 : 2'd3);
  end
`ifdef OLLAR_ARB_RANGE_CHECK_EN
  assign a_bad = |a.addr[BUS_AW-1:ADDR_WIDTH];
  assign b_bad = |b.addr[BUS_AW-1:ADDR_WIDTH];
  assign Err = b.valid && b_bad ? onehot(b.port) : '0;
`else
  assign a_bad = 1'b0;
  assign b_bad = 1'b0;
`endif
  assign unused = ^{a.addr, b.addr, b.wdata};
  // A write committing on a reset edge must not land in the RAM.
  assign ram_we = a.valid && a.we && !a_bad && !RESET_PIN;
  always_ff @(posedge CLOCK_PIN) begin
    if (RESET_PIN) begin
      a <= stage_t'('0);
      b <= stage_t'('0);
      last <= 2'd3;
    end else begin
      a <= |rot ? stage_t'{valid: 1'b1, port: gnt, addr: Address[gnt*BUS_AW +: BUS_AW],
                           wdata: WData[gnt*DATA_WIDTH +: DATA_WIDTH], we: Write[gnt]}
                : stage_t'('0);
      b <= a;
      if (|rot) last <= gnt;
    end
  end
  ollar_ram #(.ADDR_WIDTH(ADDR_WIDTH), .DATA_WIDTH(DATA_WIDTH)) u_ram (
    .clk(CLOCK_PIN),
    .we(ram_we),
    .addr(a.addr[ADDR_WIDTH-1:0]),
    .wdata(a.wdata),
    .rdata(rdata)
  );
  always_comb Ack = b.valid ? onehot(b.port) : '0;
  for (genvar g = 0; g < NUM_PORTS; g++) begin : g_rdata
    assign RData[g*DATA_WIDTH +: DATA_WIDTH] = Ack[g] && !b.we && !b_bad ? rdata : '0;
  end
endmodule

// File: doc/ollar_mem_arbiter.md
# ollar_mem_arbiter

Four-port round-robin arbiter with a shared single-port word RAM, sitting directly downstream of the four OLLAR cores. It accepts each core's Address/Write/Output bus and returns read data on that core's Input bus. Requests are pipelined: one memory access per cycle aggregate, fixed 2-cycle request-to-acknowledge latency, with no port starved.

## Interface
- ADDR_WIDTH, 10: RAM word-address bits; depth = 2**ADDR_WIDTH words.
- DATA_WIDTH, 32: word width; matches the core data buses.
- CLOCK_PIN  in  1  system clock; all logic on rising edge.
- RESET_PIN  in  1  synchronous, active-high reset.
- Req  in  4  per-port request, bit p = core p.
- Write  in  4  per-port write enable, qualified by Req.
- Address  in  4x32  per-port word address, core p on bits [32p+31:32p].
- WData  in  4xDATA_WIDTH  per-port write data (core Output bus).
- RData  out  4xDATA_WIDTH  per-port read data (core Input bus).
- Ack  out  4  per-port one-cycle completion pulse.
- Err  out  4  per-port range-error pulse; present only with OLLAR_ARB_RANGE_CHECK_EN.

## Operation
- A port is *pending* while its transaction sits in stage A or stage B, including its Ack cycle. Req from a pending port is ignored.
- Arbitration happens each cycle over non-pending ports with Req=1. The search starts at (last_granted+1) mod 4. The winner's port, address, write data and write flag are registered into stage A, and last_granted is updated.
- Stage A to stage B (next edge):
  - Write: RAM[addr] <= WData.
  - Read: RAM read data is registered.
  - The stage B valid bit and port id are set.
- While stage B is valid, Ack[port]=1 and RData[port] = registered read data (0 for a write).
  - All other Ack bits are 0.
  - All RData words are 0 whenever the port's Ack is 0.
- Requester contract:
  - Hold Req, Write, Address and WData stable from assertion until its Ack cycle.
  - Drop Req in the Ack cycle, or keep it high to issue a new request; it is re-arbitrated from the cycle after Ack.
- Back-to-back transactions in order see each other: a read granted the cycle after a write to the same address returns the new data.
- Reset state:
  - Stage A and B valid = 0.
  - last_granted = 3, so port 0 has first priority.
  - Ack = 0, RData = 0, Err = 0.
  - RAM contents are not reset.
- Reset mid-operation: in-flight transactions are discarded with no Ack. A RAM write whose commit edge coincides with RESET_PIN=1 is suppressed.

## Timing
- Req rises in cycle 0 with no competition: granted at edge ending cycle 0, RAM access at edge ending cycle 1, Ack high for all of cycle 2.
- Latency: exactly 2 cycles when uncontended. Add one cycle per competing port granted ahead of it, up to 3 extra.
- Throughput: one grant per cycle aggregate. A single port gets at most one grant per 3 cycles.
- Four simultaneous requests from reset: grant order 0,1,2,3. Acks fall in cycles 2,3,4,5.

## Configuration
- OLLAR_ARB_RANGE_CHECK_EN defined:
  - Address bits [31:ADDR_WIDTH] must be zero.
  - Otherwise the write is suppressed, read data is 0, and Err[port] pulses together with Ack[port].
- Not defined: upper address bits are ignored (addresses alias modulo depth), and the Err port does not exist.

## Structure
- Package ollar_pkg holds:
  - NUM_PORTS = 4.
  - Port-id typedef (2 bits).
  - Stage record typedef: valid, port, addr, wdata, we.
- Sub-module ollar_ram: single-port synchronous RAM (ADDR_WIDTH, DATA_WIDTH), registered read, write-enable gated by the arbiter.
- Round-robin pick logic stays inline in ollar_mem_arbiter.

## Test plan
- Port 0 writes 0xDEADBEEF to addr 5, then reads addr 5. Two Acks on port 0, cycles 2 and 5 after the first Req. Read RData[0] = 0xDEADBEEF; write-Ack RData = 0.
- All four ports read simultaneously after reset, port p from addr p preloaded with p+0x10. Acks in order 0,1,2,3 on consecutive cycles, each with the correct data.
- Ports 1 and 2 hold Req continuously for 20 cycles. Grants alternate 1,2,1,2; neither port waits more than 3 cycles between Acks.
- Port 3 writes 0x1 to addr 7, and port 0 reads addr 7 in the next grant slot. Port 0 receives 0x1.
- RESET_PIN asserted the cycle after port 2's write to addr 9 (old 0xAAAA) is granted. No Ack occurs and addr 9 still reads 0xAAAA.
- With OLLAR_ARB_RANGE_CHECK_EN, port 1 writes 0x5 to address 0x400 (ADDR_WIDTH=10). Ack[1] and Err[1] pulse together; addr 0 is unchanged. Without the macro, addr 0 becomes 0x5.
